// File: rtl/stepper_phase_sequencer_pkg.sv
// Shared constants for the stepper phase sequencer: phase index width,
// table size and the half-step coil pattern table.
package stepper_phase_sequencer_pkg;

  localparam int PHASE_W    = 3;
  localparam int TABLE_SIZE = 8;

  typedef logic [PHASE_W-1:0] phase_idx_t;
  typedef logic [3:0]         coil_t;

  // Odd indices are the two-coil phases used by full-step mode.
  localparam coil_t PHASE_TABLE [TABLE_SIZE] = '{
    4'b1000, 4'b1100, 4'b0100, 4'b0110,
    4'b0010, 4'b0011, 4'b0001, 4'b1001
  };

  function automatic coil_t phase_coil(input phase_idx_t idx);
    return PHASE_TABLE[idx];
  endfunction

endpackage

// File: rtl/stepper_phase_sequencer_idle_timer.sv
// Counts enabled cycles since the last accepted step and flags when the
// coils should be de-energised. idle_next_o is the value idle_o takes next.
module idle_timer #(
  parameter int IDLE_CYCLES = 50_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic accept_i,
  output logic idle_o,
  output logic idle_next_o
);

  localparam int CNT_W = (IDLE_CYCLES < 1) ? 1 : $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(IDLE_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             idle_q, idle_d;

  // Holds while disabled, saturates at the timeout.
  always_comb begin
    cnt_d = cnt_q;
    if (accept_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != IDLE_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    idle_d = (cnt_d == IDLE_MAX);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      idle_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idle_q <= idle_d;
    end
  end

  assign idle_o      = idle_q;
  assign idle_next_o = idle_d;

endmodule

// File: rtl/stepper_phase_sequencer.sv
// Stepper phase sequencer: walks a 3-bit phase index through the coil table
// on accepted steps, tracks signed position and blanks coils on idle timeout.
module stepper_phase_sequencer
  import stepper_phase_sequencer_pkg::*;
#(
  parameter int IDLE_CYCLES = 50_000_000,
  parameter int POS_W       = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    step,
  input  logic                    dir,
  input  logic                    half_step,
  output logic [3:0]              coil,
  output logic signed [POS_W-1:0] position,
  output logic                    idle
);

  phase_idx_t       idx_q, idx_d;
  logic [POS_W-1:0] pos_q, pos_d;
  coil_t            coil_q, coil_d;
  logic             accept;
  logic [1:0]       step_mag;
  logic             idle_next;

  assign accept = enable & step;

  // Full-step from an odd (two-coil) index jumps two; from even it realigns by one.
  assign step_mag = (!half_step && idx_q[0]) ? 2'd2 : 2'd1;

  always_comb begin
    idx_d = idx_q;
    pos_d = pos_q;
    if (accept) begin
      if (dir) begin
        idx_d = idx_q + PHASE_W'(step_mag);
        pos_d = pos_q + POS_W'(step_mag);
      end else begin
        idx_d = idx_q - PHASE_W'(step_mag);
        pos_d = pos_q - POS_W'(step_mag);
      end
    end
    coil_d = (enable && !idle_next) ? phase_coil(idx_d) : 4'b0000;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q  <= '0;
      pos_q  <= '0;
      coil_q <= 4'b0000;
    end else begin
      idx_q  <= idx_d;
      pos_q  <= pos_d;
      coil_q <= coil_d;
    end
  end

  idle_timer #(
    .IDLE_CYCLES(IDLE_CYCLES)
  ) u_idle_timer (
    .clk_i      (clock),
    .rst_i      (reset),
    .enable_i   (enable),
    .accept_i   (accept),
    .idle_o     (idle),
    .idle_next_o(idle_next)
  );

  assign coil     = coil_q;
  assign position = pos_q;

endmodule

// File: doc/stepper_phase_sequencer.md
STEPPER_PHASE_SEQUENCER -- requirements
Module: stepper_phase_sequencer

Interface
REQ-001 Parameter IDLE_CYCLES, default 50_000_000: number of consecutive cycles without an accepted step before the coils are de-energised.
REQ-002 Parameter POS_W, default 16: width of the signed position counter.
REQ-003 Port clock, input, 1: the single clock; all logic on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port enable, input, 1: 1 = driver active; 0 = coils off, steps ignored.
REQ-006 Port step, input, 1: step request from the wheel rate divider; every cycle it is high counts as one request.
REQ-007 Port dir, input, 1: direction; 1 = forward (index increments), 0 = reverse (index decrements).
REQ-008 Port half_step, input, 1: 1 = half-step mode; 0 = full-step (two-coil-on) mode.
REQ-009 Port coil, output, 4: registered coil drive, bit 3 = coil A through bit 0 = coil D.
REQ-010 Port position, output, POS_W: signed position in half-step units.
REQ-011 Port idle, output, 1: registered flag; 1 while the coils are de-energised by timeout.

Function
REQ-012 Phase index shall be 3 bits, 0..7, wrapping modulo 8 in both directions.
REQ-013 Phase table shall be 0:1000, 1:1100, 2:0100, 3:0110, 4:0010, 5:0011, 6:0001, 7:1001.
REQ-014 A step is accepted in a cycle when enable=1 and step=1.
REQ-015 In half-step mode, an accepted step shall move the index by ±1.
REQ-016 In full-step mode, an accepted step shall move the index by ±2 from an odd index, or by ±1 from an even index, so the driver realigns to an odd (two-coil) phase.
REQ-017 position shall change by the same signed delta applied to the index (±1 or ±2) and shall wrap in two's complement at its limits.
REQ-018 Latency: coil, position and idle shall reflect an accepted step on the cycle after it is sampled.
REQ-019 If step is high for N consecutive enabled cycles, exactly N steps shall be taken, one per cycle.
REQ-020 dir and half_step shall be sampled only in the cycle a step is accepted; changes between steps have no effect.
REQ-021 When enable=0, coil shall be 0000 and index, position and the idle counter shall hold.
REQ-022 When enable returns to 1 and idle=0, coil shall show the phase of the held index, with no step taken.
REQ-023 The idle counter shall clear on each accepted step and otherwise increment while enable=1, saturating at IDLE_CYCLES.
REQ-024 When the idle counter reaches IDLE_CYCLES, idle shall be 1 and coil shall be 0000 from the next cycle.
REQ-025 A step accepted while idle=1 shall advance the index normally, drive the new phase and clear idle, all in the same output update.
REQ-026 Reset asserted mid-operation shall override any step in the same cycle.

Reset
REQ-027 On reset the phase index shall be 0, position 0, idle counter 0, and idle 0.
REQ-028 On reset, coil shall be 0000 for the reset cycle, then show the phase-0 pattern 1000 once enable=1.

Structure
REQ-029 A shared package shall hold the 8-entry phase table constant, the phase-index width (3) and the table size (8).
REQ-030 The idle timeout counter shall be a single sub-module, idle_timer, parameterised by IDLE_CYCLES; all other logic stays in stepper_phase_sequencer.

Verification
REQ-031 Reset, enable=1, half_step=1, dir=1, step high for 9 cycles -> coil walks 1100,0100,...,1001,1000,1100; position=9.
REQ-032 From index 0 (even), half_step=0, dir=1, 3 single-cycle steps -> index 1,3,5; coil 1100,0110,0011; position=5.
REQ-033 dir=0 from reset, half_step=1, 1 step -> index 7, coil 1001, position=-1.
REQ-034 IDLE_CYCLES=10, no steps for 10 cycles -> idle=1 and coil=0000; then 1 step -> idle=0 and the next phase is driven on the following cycle.
REQ-035 enable=0 with step held high for 5 cycles -> coil=0000, position unchanged; then enable=1 -> held phase restored, no step taken.
REQ-036 POS_W=4, position=7, 1 forward half step -> position=-8; reset asserted together with step -> position=0, index 0.
